pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline controller for the five-stage MIPS core (IF/ID/EX/MEM/WB). It merges per-stage stall requests into per-stage stall and flush enables, and supplies the `id_stall_i` / `id_flush_i` pair consumed by the decoder and its siblings. It also sequences exception and ERET redirects, holding the redirect until any in-flight instruction fetch drains, and keeps a saturating stall-cycle counter.

## Interface
- `EXC_VECTOR`, default 32'hBFC0_0380: general exception entry PC.
- `CNT_W`, default 32: width of stall-cycle counter.

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous, active-low reset
- `if_stallreq_i`  in  1  fetch not ready (icache miss)
- `id_stallreq_i`  in  1  load-use / operand hazard
- `ex_stallreq_i`  in  1  MDU busy (div/mult in progress)
- `mem_stallreq_i`  in  1  dcache / data bus wait
- `if_busy_i`  in  1  IF has an outstanding fetch that cannot be cancelled
- `mem_exc_i`  in  1  exception committed in MEM this cycle
- `mem_eret_i`  in  1  ERET committed in MEM this cycle
- `cp0_epc_i`  in  32  current EPC
- `stall_o`  out  5  per-stage stall, bit 0 = IF … bit 4 = WB
- `flush_o`  out  5  per-stage flush (insert bubble), same bit order
- `redirect_en_o`  out  1  one-cycle PC redirect strobe to IF
- `redirect_pc_o`  out  32  redirect target, valid with `redirect_en_o`
- `stall_cnt_o`  out  CNT_W  cycles with any `stall_o` bit set, saturating

## Operation
- FSM states: IDLE, DRAIN.
- IDLE, no exc/eret: stall source = highest asserting stage k among {MEM=3, EX=2, ID=1, IF=0}. `stall_o[j]=1` for all j≤k; `flush_o[k+1]=1` (bubble into next stage); all other bits 0. No request → all zero.
- IDLE, `mem_exc_i` or `mem_eret_i`: stall requests ignored this cycle; `flush_o[3:0]=4'b1111`, `stall_o=0`. Capture target (`EXC_VECTOR` if `mem_exc_i`, else `cp0_epc_i`; exc wins if both). Go DRAIN.
- DRAIN: `flush_o[3:0]=4'b1111`, `stall_o=0`. If `if_busy_i=0`: `redirect_en_o=1`, `redirect_pc_o`=captured target, next state IDLE. Otherwise stay in DRAIN. New `mem_exc_i`/`mem_eret_i` in DRAIN are ignored (the pipeline is already flushed).
- `flush_o[4]` is never asserted; WB always completes.
- `stall_cnt_o` increments on every cycle where `stall_o!=0` and holds at all-ones.

## Timing
- Stall and flush outputs are combinational from current inputs and state, taking effect the same cycle.
- Redirect is registered from state: exception at cycle T gives earliest `redirect_en_o` at T+1. With `if_busy_i` high for n cycles from T+1, redirect fires at T+1+n.
- `redirect_en_o` is high for exactly one cycle per exception or ERET.
- Reset (async, any time including DRAIN) produces state IDLE, `redirect_en_o=0`, `redirect_pc_o=0`, `stall_cnt_o=0`. `stall_o`/`flush_o` evaluate to 0 while `rst_n=0`. A pending redirect is discarded.
- Decoder hookup: `id_stall_i=stall_o[1]`, `id_flush_i=flush_o[1]`.

## Structure
- Add the following to the shared defines header: stage index constants (`STG_IF`..`STG_WB`), FSM state encoding, and the `EXC_VECTOR` default.
- Implement state, target and counter registers with the existing `DFFRE` cell (en=1 for state).
- No new sub-module; the priority encoder is inline logic.

## Test plan
- Only `ex_stallreq_i=1` for 3 cycles → `stall_o=5'b00111`, `flush_o=5'b01000` each cycle; `stall_cnt_o` goes 0→3.
- `id_stallreq_i` and `mem_stallreq_i` both high → `stall_o=5'b01111`, `flush_o=5'b10000`? No: WB flush is suppressed, so the expected response is `flush_o=0`.
- `mem_exc_i` pulse at T, `if_busy_i=0` → `flush_o=5'b01111` at T and T+1; `redirect_en_o=1`, `redirect_pc_o=32'hBFC00380` at T+1 only.
- `mem_eret_i` at T with `cp0_epc_i=32'h8000_1234` and `if_busy_i` high T+1..T+3 → flushes held through T+4; redirect to 32'h80001234 at T+4.
- `rst_n` low during DRAIN → no redirect ever issued; all outputs 0 after release.
- Counter saturation: with `CNT_W=4`, 20 stall cycles → `stall_cnt_o=4'hF`.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline controller definitions: stage indices, FSM states, reset vector.
package pipe_ctrl_pkg;

  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EX  = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall/flush merge, exception/ERET redirect
// sequencing with fetch drain, and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_stallreq_i,
  input  logic             id_stallreq_i,
  input  logic             ex_stallreq_i,
  input  logic             mem_stallreq_i,
  input  logic             if_busy_i,
  input  logic             mem_exc_i,
  input  logic             mem_eret_i,
  input  logic [31:0]      cp0_epc_i,
  output logic [4:0]       stall_o,
  output logic [4:0]       flush_o,
  output logic             redirect_en_o,
  output logic [31:0]      redirect_pc_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  ctrl_state_t state;

  // Stall/flush merge: redirect handling overrides stall requests; otherwise the
  // highest requesting stage stalls itself and everything upstream and bubbles
  // the next stage. WB is never flushed so a MEM stall produces no flush.
  always_comb begin
    stall_o = '0;
    flush_o = '0;
    if (rst_n) begin
      if (state == ST_DRAIN || mem_exc_i || mem_eret_i) begin
        flush_o[STG_MEM:STG_IF] = '1;
      end else if (mem_stallreq_i) begin
        stall_o[STG_MEM:STG_IF] = '1;
      end else if (ex_stallreq_i) begin
        stall_o[STG_EX:STG_IF] = '1;
        flush_o[STG_MEM]       = 1'b1;
      end else if (id_stallreq_i) begin
        stall_o[STG_ID:STG_IF] = '1;
        flush_o[STG_EX]        = 1'b1;
      end else if (if_stallreq_i) begin
        stall_o[STG_IF] = 1'b1;
        flush_o[STG_ID] = 1'b1;
      end
      flush_o[STG_WB] = 1'b0;
    end
  end

  // Redirect strobe fires in the first DRAIN cycle where the fetch unit is idle.
  always_comb begin
    redirect_en_o = rst_n && (state == ST_DRAIN) && !if_busy_i;
  end

  // Redirect FSM: capture target on exc/eret in IDLE, hold in DRAIN until fetch drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      redirect_pc_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_exc_i || mem_eret_i) begin
            state         <= ST_DRAIN;
            redirect_pc_o <= mem_exc_i ? EXC_VECTOR : cp0_epc_i;
          end
        end
        ST_DRAIN: begin
          if (!if_busy_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Saturating count of cycles with any stage stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if ((|stall_o) && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// against a behavioural model of the stall/flush/redirect rules.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, id_req, ex_req, mem_req;
  logic        if_busy, mem_exc, mem_eret;
  logic [31:0] epc;

  logic [4:0]  stall, flush, stall_s, flush_s;
  logic        ren, ren_s;
  logic [31:0] rpc, rpc_s;
  logic [31:0] cnt;
  logic [3:0]  cnt4;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  // model state
  bit          m_pending;
  logic [31:0] m_tgt;
  longint      m_cnt;
  int          m_cnt4;
  int unsigned n_redirects;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  always #5 clk = ~clk;

  pipe_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_stallreq_i(if_req), .id_stallreq_i(id_req),
    .ex_stallreq_i(ex_req), .mem_stallreq_i(mem_req),
    .if_busy_i(if_busy), .mem_exc_i(mem_exc), .mem_eret_i(mem_eret),
    .cp0_epc_i(epc),
    .stall_o(stall), .flush_o(flush),
    .redirect_en_o(ren), .redirect_pc_o(rpc), .stall_cnt_o(cnt)
  );

  pipe_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .if_stallreq_i(if_req), .id_stallreq_i(id_req),
    .ex_stallreq_i(ex_req), .mem_stallreq_i(mem_req),
    .if_busy_i(if_busy), .mem_exc_i(mem_exc), .mem_eret_i(mem_eret),
    .cp0_epc_i(epc),
    .stall_o(stall_s), .flush_o(flush_s),
    .redirect_en_o(ren_s), .redirect_pc_o(rpc_s), .stall_cnt_o(cnt4)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected combinational outputs from the current inputs and model state.
  task automatic expect_comb(output logic [4:0] e_stall, output logic [4:0] e_flush,
                             output logic e_ren);
    int k;
    e_stall = '0;
    e_flush = '0;
    e_ren   = 1'b0;
    if (!rst_n) return;
    if (m_pending) begin
      e_flush = 5'h0F;
      e_ren   = !if_busy;
    end else if (mem_exc || mem_eret) begin
      e_flush = 5'h0F;
    end else begin
      k = mem_req ? 3 : ex_req ? 2 : id_req ? 1 : if_req ? 0 : -1;
      if (k >= 0) begin
        e_stall = 5'((1 << (k + 1)) - 1);
        if (k + 1 < 4) e_flush = 5'(1 << (k + 1));
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [4:0] es, ef;
    logic       er;
    expect_comb(es, ef, er);
    check_eq({tag, ".stall"}, 64'(stall), 64'(es));
    check_eq({tag, ".flush"}, 64'(flush), 64'(ef));
    check_eq({tag, ".ren"},   64'(ren),   64'(er));
    check_eq({tag, ".rpc"},   64'(rpc),   64'(m_tgt));
    check_eq({tag, ".cnt"},   64'(cnt),   64'(m_cnt));
    check_eq({tag, ".cnt4"},  64'(cnt4),  64'(m_cnt4));
    if (er && ren === 1'b1) n_redirects++;
  endtask

  task automatic model_reset();
    m_pending = 0;
    m_tgt     = '0;
    m_cnt     = 0;
    m_cnt4    = 0;
  endtask

  // Apply one cycle of inputs, check mid-cycle, then advance the model at the edge.
  task automatic cyc(input string tag, input logic [3:0] reqs, input logic busy,
                     input logic exc, input logic eret, input logic [31:0] pc);
    logic [4:0] es, ef;
    logic       er;
    @(negedge clk);
    {mem_req, ex_req, id_req, if_req} = reqs;
    if_busy  = busy;
    mem_exc  = exc;
    mem_eret = eret;
    epc      = pc;
    #1;
    check_all(tag);
    expect_comb(es, ef, er);
    @(posedge clk);
    if (rst_n) begin
      if (es != 0) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (m_pending) begin
        if (!busy) m_pending = 0;
      end else if (exc || eret) begin
        m_pending = 1;
        m_tgt     = exc ? VEC : pc;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {if_req, id_req, ex_req, mem_req, if_busy, mem_exc, mem_eret} = '0;
    epc = '0;
    n_redirects = 0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // EX-only stall for three cycles
    repeat (3) cyc("ex_stall", 4'b0100, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc("ex_after", 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("ex_cnt3", 64'(cnt), 64'd3);

    // ID + MEM together: MEM wins, no WB flush
    cyc("id_mem", 4'b1010, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc("if_only", 4'b0001, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc("id_only", 4'b0010, 1'b0, 1'b0, 1'b0, 32'h0);

    // Exception, fetch idle: redirect next cycle
    cyc("exc_T", 4'b0110, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc("exc_T1", 4'b0110, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("exc_vec", 64'(rpc), 64'(VEC));
    cyc("exc_T2", 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);

    // ERET with fetch busy for three cycles, new exc ignored while draining
    cyc("eret_T", 4'b0000, 1'b1, 1'b0, 1'b1, 32'h8000_1234);
    cyc("eret_b1", 4'b1000, 1'b1, 1'b1, 1'b0, 32'h0);
    cyc("eret_b2", 4'b0000, 1'b1, 1'b0, 1'b1, 32'h0);
    cyc("eret_b3", 4'b0000, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc("eret_T4", 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("eret_pc", 64'(rpc), 64'h8000_1234);
    cyc("eret_T5", 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset during DRAIN discards the redirect
    cyc("rd_exc", 4'b0000, 1'b1, 1'b1, 1'b0, 32'h0);
    cyc("rd_busy", 4'b0000, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    if_busy = 1'b0;
    {mem_req, ex_req, id_req, if_req} = 4'b1111;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst_drain");
    @(negedge clk);
    rst_n = 1'b1;
    {mem_req, ex_req, id_req, if_req} = 4'b0000;
    n_redirects = 0;
    repeat (3) cyc("post_rst", 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("post_rst_noredir", 64'(n_redirects), 64'd0);

    // Saturation of the 4-bit counter
    repeat (20) cyc("sat", 4'b0001, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc("sat_end", 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("sat_cnt4", 64'(cnt4), 64'hF);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] r;
      logic b, e, t;
      r = 4'($urandom);
      b = ($urandom_range(0, 2) == 0);
      e = ($urandom_range(0, 15) == 0);
      t = ($urandom_range(0, 15) == 0);
      cyc("rand", r, b, e, t, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
